// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- small vectored interrupt controller for a port-mapped CPU.
//
// Collects rising edges on up to eight IRQ lines into a PENDING register,
// gates them with a software-written MASK register, and presents the
// lowest-index pending & enabled source to the ControlUnit as a single
// registered request with a 3-bit source index. One interrupt is in service
// at a time; a new request is only raised after INT_DONE.
//
// Optional build macro:
//   INTC_SYNC_EN  - when defined, each IRQ line passes a 2-flop synchronizer
//                   before edge detection (adds 2 cycles of latency). When
//                   undefined, IRQ must already be synchronous to clk.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   irq        in   [N_SRC] raw interrupt request lines, rising-edge sensitive
//   port_id    in   [8] CPU I/O port address
//   out_port   in   [8] CPU I/O write data
//   io_strb    in   CPU I/O write strobe, one cycle per OUT
//   int_ack    in   pulse from ControlUnit when it takes the interrupt
//   int_done   in   pulse from ControlUnit on RETIE/RETID
//   interrupt  out  registered interrupt request
//   int_id     out  [3] index of the source being requested or serviced
//   in_data    out  [8] read data for CPU IN (combinational)
//   rd_hit     out  high when port_id addresses MASK_PORT or STAT_PORT
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int         N_SRC     = 8,
  parameter logic [7:0] MASK_PORT = 8'hF0,
  parameter logic [7:0] STAT_PORT = 8'hF1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq,
  input  logic [7:0]       port_id,
  input  logic [7:0]       out_port,
  input  logic             io_strb,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             interrupt,
  output logic [2:0]       int_id,
  output logic [7:0]       in_data,
  output logic             rd_hit
);

  // REQ is encoded with only bit 0 set so the request output is a direct
  // decode of a single state flop and cannot glitch.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t state, state_next;

  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [7:0]       active_ext;
  logic [7:0]       ack_clr_ext;
  logic [7:0]       mask_ext;
  logic [7:0]       pending_ext;
  logic [2:0]       win_idx;
  logic             mask_hit;
  logic             stat_hit;
  logic             mask_wr;
  logic             stat_wr;
  logic             ack_take;
  logic             any_active;

  // Input conditioning: optionally resynchronise the IRQ lines before they
  // reach the edge detector.
`ifdef INTC_SYNC_EN
  logic [N_SRC-1:0] irq_meta;
  logic [N_SRC-1:0] irq_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= irq;
      irq_sync <= irq_meta;
    end
  end

  assign irq_s = irq_sync;
`else
  assign irq_s = irq;
`endif

  // History register for edge detection. Cleared on reset so that a line
  // already high at reset release is seen as a fresh edge on the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_s;
    end
  end

  assign irq_edge = irq_s & ~irq_prev;

  // I/O decode shared by the read mux and the register write enables.
  assign mask_hit = (port_id == MASK_PORT);
  assign stat_hit = (port_id == STAT_PORT);
  assign mask_wr  = io_strb & mask_hit;
  assign stat_wr  = io_strb & stat_hit;
  assign rd_hit   = mask_hit | stat_hit;

  assign active     = pending & mask;
  assign any_active = |active;
  assign ack_take   = (state == REQ) & int_ack;
  assign w1c_clr    = stat_wr ? out_port[N_SRC-1:0] : '0;

  // Zero-extended 8-bit views so a 3-bit index is always in range, whatever
  // N_SRC is; bits at or above N_SRC stay 0.
  always_comb begin
    active_ext              = '0;
    active_ext[N_SRC-1:0]   = active;
    mask_ext                = '0;
    mask_ext[N_SRC-1:0]     = mask;
    pending_ext             = '0;
    pending_ext[N_SRC-1:0]  = pending;
    ack_clr_ext             = '0;
    if (ack_take) begin
      ack_clr_ext[int_id] = 1'b1;
    end
    ack_clr = ack_clr_ext[N_SRC-1:0];
  end

  // Fixed priority: scanning from the top down leaves the lowest set index.
  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_idx = 3'(i);
      end
    end
  end

  // PENDING and MASK registers. A new edge is OR-ed in after the clears so
  // that a simultaneous set and clear on the same bit leaves it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~w1c_clr & ~ack_clr) | irq_edge;
      if (mask_wr) begin
        mask <= out_port[N_SRC-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. In REQ an acknowledge takes precedence over the
  // latched source having disappeared in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_active) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_next = SERVICE;
        end else if (!active_ext[int_id]) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Source index is captured only when a request is launched, so a later
  // higher-priority edge cannot change it while in REQ or SERVICE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_id <= '0;
    end else if ((state == IDLE) && any_active) begin
      int_id <= win_idx;
    end
  end

  // FSM output logic.
  always_comb begin
    interrupt = (state == REQ);
  end

  // CPU read mux.
  always_comb begin
    in_data = 8'h00;
    if (mask_hit) begin
      in_data = mask_ext;
    end else if (stat_hit) begin
      in_data = pending_ext;
    end
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_SRC, 8, number of interrupt sources (1..8).
REQ-002 Parameter MASK_PORT, 8'hF0, I/O port ID of the enable-mask register.
REQ-003 Parameter STAT_PORT, 8'hF1, I/O port ID of the pending/status register.
REQ-004 CLK  in  1  single system clock; all state changes on rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 IRQ  in  N_SRC  raw interrupt request lines, rising-edge sensitive.
REQ-007 PORT_ID  in  8  CPU I/O port address.
REQ-008 OUT_PORT  in  8  CPU I/O write data.
REQ-009 IO_STRB  in  1  CPU I/O write strobe, one cycle per OUT.
REQ-010 INT_ACK  in  1  one-cycle pulse from the ControlUnit when it takes the interrupt.
REQ-011 INT_DONE  in  1  one-cycle pulse from the ControlUnit on RETIE/RETID.
REQ-012 INTERRUPT  out  1  registered interrupt request to the ControlUnit.
REQ-013 INT_ID  out  3  index of the source being requested or serviced.
REQ-014 IN_DATA  out  8  read data for CPU IN.
REQ-015 RD_HIT  out  1  high when PORT_ID equals MASK_PORT or STAT_PORT.

Function
REQ-016 Edge detect: each IRQ bit is registered; edge = current & ~registered; a detected edge sets the matching PENDING bit on that clock edge.
REQ-017 PENDING and MASK are N_SRC bits each; bits at or above N_SRC read as 0 and ignore writes.
REQ-018 IO_STRB with PORT_ID==MASK_PORT loads MASK from OUT_PORT[N_SRC-1:0].
REQ-019 IO_STRB with PORT_ID==STAT_PORT clears every PENDING bit whose OUT_PORT bit is 1 (write-1-to-clear).
REQ-020 Same-cycle set (edge) and clear (W1C or ack) on one bit: set wins.
REQ-021 IN_DATA is combinational: {0,MASK} at MASK_PORT, {0,PENDING} at STAT_PORT, 8'h00 otherwise.
REQ-022 Priority: lowest-index bit of (PENDING & MASK) wins.
REQ-023 FSM states IDLE, REQ, SERVICE.
REQ-024 IDLE -> REQ when (PENDING & MASK) != 0; INT_ID latched to the winner; INTERRUPT high from the next cycle.
REQ-025 In REQ, INTERRUPT stays high until INT_ACK; INT_ID is frozen (a later higher-priority source does not preempt).
REQ-026 REQ + INT_ACK -> SERVICE; PENDING[INT_ID] cleared; INTERRUPT low the next cycle.
REQ-027 REQ with the latched source no longer pending&masked (masked or W1C-cleared) and no INT_ACK -> IDLE; INTERRUPT dropped.
REQ-028 SERVICE -> IDLE on INT_DONE; no new request is issued while in SERVICE (no nesting).
REQ-029 INT_ACK outside REQ and INT_DONE outside SERVICE are ignored.
REQ-030 Latency, sync disabled: IRQ rises before edge n -> PENDING set after n -> INTERRUPT high after n+1.

Reset
REQ-031 RESET_N low asynchronously forces: state IDLE, PENDING=0, MASK=0, IRQ history registers=0, INTERRUPT=0, INT_ID=0.
REQ-032 A request or service in flight is abandoned on reset; no INT_ACK/INT_DONE is required afterwards.
REQ-033 IRQ lines already high when RESET_N releases produce an edge on the first clock, so they are captured as pending.

Configuration
REQ-034 Macro INTC_SYNC_EN: when defined, each IRQ passes a 2-flop synchronizer (reset to 0) before edge detect, adding exactly 2 cycles to REQ-030 latency.
REQ-035 Without INTC_SYNC_EN, edge detect samples IRQ directly; IRQ must be synchronous to CLK.

Verification
REQ-036 MASK=8'hFF, pulse IRQ[3] -> PENDING=8'h08, INTERRUPT high at REQ-030 latency, INT_ID=3; INT_ACK -> PENDING=0, INTERRUPT low.
REQ-037 MASK=8'hFF, IRQ[5] and IRQ[2] rise in the same cycle -> INT_ID=2; after ACK and DONE, second request with INT_ID=5.
REQ-038 MASK=8'h00, pulse IRQ[1] -> PENDING=8'h02, INTERRUPT stays 0; write MASK=8'h02 -> INTERRUPT high, INT_ID=1.
REQ-039 In REQ for source 4, write 8'h10 to STAT_PORT before ACK -> FSM to IDLE, INTERRUPT low, PENDING=0.
REQ-040 IRQ[0] edge in the same cycle as W1C 8'h01 -> PENDING[0] stays 1; IN at STAT_PORT returns 8'h01, RD_HIT=1.
REQ-041 RESET_N low while in SERVICE -> all outputs 0 immediately, without waiting for CLK; with INTC_SYNC_EN, IRQ-to-INTERRUPT latency measured as 4 cycles.
